// File: rtl/hot_page_topk_cam_if.sv
// Estimate-in / readout-out bundle for the sorted top-K hot page CAM.
interface hot_page_topk_cam_if #(
    parameter int unsigned ADDR_SIZE = 22,
    parameter int unsigned CNT_SIZE  = 32
);
    logic                 input_valid;
    logic [ADDR_SIZE-1:0] input_addr;
    logic [CNT_SIZE-1:0]  input_cnt;
    logic                 drain_start;
    logic                 out_valid;
    logic                 out_ready;
    logic [ADDR_SIZE-1:0] out_addr;
    logic [CNT_SIZE-1:0]  out_cnt;
    logic                 out_last;

    modport master (
        output input_valid, input_addr, input_cnt, drain_start, out_ready,
        input  out_valid, out_addr, out_cnt, out_last
    );

    modport slave (
        input  input_valid, input_addr, input_cnt, drain_start, out_ready,
        output out_valid, out_addr, out_cnt, out_last
    );
endinterface

// File: rtl/hot_page_topk_cam.sv
// Sorted top-K CAM: keeps the NUM_ENTRY hottest page addresses, entry 0 hottest,
// and streams them out hottest-first on request before clearing for the next epoch.
module hot_page_topk_cam #(
    parameter int unsigned NUM_ENTRY = 16,
    parameter int unsigned ADDR_SIZE = 22,
    parameter int unsigned CNT_SIZE  = 32,
    parameter int unsigned DROP_SIZE = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    hot_page_topk_cam_if.slave               bus_io,
    output logic                             drain_done_o,
    output logic                             busy_o,
    output logic [$clog2(NUM_ENTRY+1)-1:0]   num_valid_o,
    output logic [DROP_SIZE-1:0]             drop_cnt_o
);
    localparam int unsigned IdxW = $clog2(NUM_ENTRY);
    localparam int unsigned NumW = $clog2(NUM_ENTRY + 1);

    typedef enum logic [1:0] {StIdle, StFlush, StDrain, StClear} state_e;

    state_e                 state_q;
    logic [IdxW-1:0]        rd_idx_q;
    logic [NumW-1:0]        num_valid_q, num_valid_d;
    logic [DROP_SIZE-1:0]   drop_cnt_q;

    logic                   s1_valid_q;
    logic [ADDR_SIZE-1:0]   s1_addr_q;
    logic [CNT_SIZE-1:0]    s1_cnt_q;

    logic [NUM_ENTRY-1:0]   valid_q, valid_d;
    logic [ADDR_SIZE-1:0]   addr_q [NUM_ENTRY];
    logic [ADDR_SIZE-1:0]   addr_d [NUM_ENTRY];
    logic [CNT_SIZE-1:0]    cnt_q  [NUM_ENTRY];
    logic [CNT_SIZE-1:0]    cnt_d  [NUM_ENTRY];

    logic                   hit;
    logic [IdxW-1:0]        hit_idx, top;
    logic [CNT_SIZE-1:0]    old_cnt, key;
    logic [NumW-1:0]        pos;
    logic                   do_write;

    // S2: match, rank and shift. A hit only ranks against entries above it so that
    // an unchanged or equal count never moves behind an incumbent.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        old_cnt = '0;
        for (int j = 0; j < NUM_ENTRY; j++) begin
            if (valid_q[j] && addr_q[j] == s1_addr_q) begin
                hit     = 1'b1;
                hit_idx = IdxW'(j);
                old_cnt = cnt_q[j];
            end
        end
        key = (hit && old_cnt > s1_cnt_q) ? old_cnt : s1_cnt_q;
        pos = '0;
        for (int j = 0; j < NUM_ENTRY; j++) begin
            if (valid_q[j] && (!hit || IdxW'(j) < hit_idx) && cnt_q[j] >= key) begin
                pos = pos + NumW'(1);
            end
        end
        top      = hit ? hit_idx : IdxW'(NUM_ENTRY - 1);
        do_write = s1_valid_q && (hit || pos != NumW'(NUM_ENTRY));

        valid_d     = valid_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        num_valid_d = num_valid_q;
        if (do_write) begin
            for (int j = 1; j < NUM_ENTRY; j++) begin
                if (NumW'(j) > pos && IdxW'(j) <= top) begin
                    valid_d[j] = valid_q[j-1];
                    addr_d[j]  = addr_q[j-1];
                    cnt_d[j]   = cnt_q[j-1];
                end
            end
            valid_d[IdxW'(pos)] = 1'b1;
            addr_d[IdxW'(pos)]  = s1_addr_q;
            cnt_d[IdxW'(pos)]   = key;
            if (!hit && num_valid_q != NumW'(NUM_ENTRY)) begin
                num_valid_d = num_valid_q + NumW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rd_idx_q    <= '0;
            num_valid_q <= '0;
            drop_cnt_q  <= '0;
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            s1_cnt_q    <= '0;
            valid_q     <= '0;
            for (int j = 0; j < NUM_ENTRY; j++) begin
                addr_q[j] <= '0;
                cnt_q[j]  <= '0;
            end
        end else begin
            s1_valid_q <= (state_q == StIdle) && bus_io.input_valid;
            if (state_q == StIdle && bus_io.input_valid) begin
                s1_addr_q <= bus_io.input_addr;
                s1_cnt_q  <= bus_io.input_cnt;
            end
            if (state_q != StIdle && bus_io.input_valid && drop_cnt_q != '1) begin
                drop_cnt_q <= drop_cnt_q + DROP_SIZE'(1);
            end

            if (state_q == StClear) begin
                valid_q     <= '0;
                num_valid_q <= '0;
                for (int j = 0; j < NUM_ENTRY; j++) begin
                    addr_q[j] <= '0;
                    cnt_q[j]  <= '0;
                end
            end else begin
                valid_q     <= valid_d;
                addr_q      <= addr_d;
                cnt_q       <= cnt_d;
                num_valid_q <= num_valid_d;
            end

            unique case (state_q)
                StIdle: if (bus_io.drain_start) state_q <= StFlush;
                StFlush: begin
                    rd_idx_q <= '0;
                    state_q  <= (num_valid_d != '0) ? StDrain : StClear;
                end
                StDrain: begin
                    if (bus_io.out_ready) begin
                        if (bus_io.out_last) state_q <= StClear;
                        else                 rd_idx_q <= rd_idx_q + IdxW'(1);
                    end
                end
                StClear: begin
                    rd_idx_q <= '0;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        bus_io.out_valid = (state_q == StDrain);
        bus_io.out_addr  = bus_io.out_valid ? addr_q[rd_idx_q] : '0;
        bus_io.out_cnt   = bus_io.out_valid ? cnt_q[rd_idx_q] : '0;
        bus_io.out_last  = bus_io.out_valid && (NumW'(rd_idx_q) == num_valid_q - NumW'(1));
        drain_done_o     = (state_q == StClear);
        busy_o           = (state_q != StIdle);
        num_valid_o      = num_valid_q;
        drop_cnt_o       = drop_cnt_q;
    end
endmodule

// File: tb/tb_hot_page_topk_cam.sv
// Directed bench for hot_page_topk_cam: inserts, re-sorts, ties, busy drops, reset mid-drain.
module tb_hot_page_topk_cam;
    localparam int unsigned NUM_ENTRY = 16;
    localparam int unsigned ADDR_SIZE = 22;
    localparam int unsigned CNT_SIZE  = 32;
    localparam int unsigned DROP_SIZE = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic drain_done, busy;
    logic [$clog2(NUM_ENTRY+1)-1:0] num_valid;
    logic [DROP_SIZE-1:0] drop_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [ADDR_SIZE-1:0] exp_addr [$];
    logic [CNT_SIZE-1:0]  exp_cnt  [$];

    hot_page_topk_cam_if #(.ADDR_SIZE(ADDR_SIZE), .CNT_SIZE(CNT_SIZE)) bus ();

    hot_page_topk_cam #(
        .NUM_ENTRY(NUM_ENTRY), .ADDR_SIZE(ADDR_SIZE), .CNT_SIZE(CNT_SIZE), .DROP_SIZE(DROP_SIZE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus_io       (bus),
        .drain_done_o (drain_done),
        .busy_o       (busy),
        .num_valid_o  (num_valid),
        .drop_cnt_o   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [ADDR_SIZE-1:0] a, input logic [CNT_SIZE-1:0] c);
        bus.input_valid = 1'b1;
        bus.input_addr  = a;
        bus.input_cnt   = c;
        tick();
    endtask

    task automatic settle();
        bus.input_valid = 1'b0;
        tick();
        tick();
    endtask

    // Drain with out_ready held high and compare against exp_addr/exp_cnt.
    task automatic drain_check(input string tag);
        int n;
        n = exp_addr.size();
        bus.out_ready   = 1'b1;
        bus.drain_start = 1'b1;
        tick();
        bus.drain_start = 1'b0;
        chk({tag, ".flush_busy"}, 64'(busy), 64'd1);
        chk({tag, ".flush_noval"}, 64'(bus.out_valid), 64'd0);
        tick();
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s.valid%0d", tag, k), 64'(bus.out_valid), 64'd1);
            chk($sformatf("%s.addr%0d", tag, k), 64'(bus.out_addr), 64'(exp_addr[k]));
            chk($sformatf("%s.cnt%0d", tag, k), 64'(bus.out_cnt), 64'(exp_cnt[k]));
            chk($sformatf("%s.last%0d", tag, k), 64'(bus.out_last), 64'(k == n - 1));
            tick();
        end
        chk({tag, ".done_pulse"}, 64'(drain_done), 64'd1);
        chk({tag, ".clear_noval"}, 64'(bus.out_valid), 64'd0);
        tick();
        chk({tag, ".done_low"}, 64'(drain_done), 64'd0);
        chk({tag, ".idle"}, 64'(busy), 64'd0);
        chk({tag, ".empty"}, 64'(num_valid), 64'd0);
        exp_addr.delete();
        exp_cnt.delete();
    endtask

    initial begin
        bus.input_valid = 1'b0;
        bus.input_addr  = '0;
        bus.input_cnt   = '0;
        bus.drain_start = 1'b0;
        bus.out_ready   = 1'b0;
        #12;
        chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.num_valid", 64'(num_valid), 64'd0);
        chk("rst.drop_cnt", 64'(drop_cnt), 64'd0);
        chk("rst.drain_done", 64'(drain_done), 64'd0);
        chk("rst.out_addr", 64'(bus.out_addr), 64'd0);
        rst = 1'b0;
        tick();

        // T1: back-to-back inserts, drain hottest first
        send(22'h11, 32'd5);
        send(22'h22, 32'd9);
        send(22'h33, 32'd7);
        bus.input_valid = 1'b0;
        tick();
        chk("t1.num_valid", 64'(num_valid), 64'd3);
        exp_addr = '{22'h22, 22'h33, 22'h11};
        exp_cnt  = '{32'd9, 32'd7, 32'd5};
        drain_check("t1");

        // T2: full table, hit on the coldest entry jumps to the top
        for (int k = 0; k < 16; k++) send(22'h100 + 22'(k), 32'(100 - k));
        settle();
        chk("t2.full", 64'(num_valid), 64'd16);
        send(22'h10F, 32'd101);
        settle();
        chk("t2.still_full", 64'(num_valid), 64'd16);
        exp_addr.push_back(22'h10F);
        exp_cnt.push_back(32'd101);
        for (int k = 0; k < 15; k++) begin
            exp_addr.push_back(22'h100 + 22'(k));
            exp_cnt.push_back(32'(100 - k));
        end
        drain_check("t2");

        // T3: miss below the minimum is dropped; tie at 90 lands behind the incumbent 90
        for (int k = 0; k < 16; k++) send(22'h100 + 22'(k), 32'(100 - k));
        send(22'h200, 32'd84);
        settle();
        chk("t3.full", 64'(num_valid), 64'd16);
        send(22'h201, 32'd90);
        settle();
        for (int k = 0; k < 11; k++) begin
            exp_addr.push_back(22'h100 + 22'(k));
            exp_cnt.push_back(32'(100 - k));
        end
        exp_addr.push_back(22'h201);
        exp_cnt.push_back(32'd90);
        for (int k = 11; k < 15; k++) begin
            exp_addr.push_back(22'h100 + 22'(k));
            exp_cnt.push_back(32'(100 - k));
        end
        drain_check("t3");

        // T4: ties keep arrival order; a lower re-send keeps the max
        send(22'h0A, 32'd7);
        send(22'h0B, 32'd7);
        send(22'h0A, 32'd3);
        settle();
        chk("t4.num_valid", 64'(num_valid), 64'd2);
        exp_addr = '{22'h0A, 22'h0B};
        exp_cnt  = '{32'd7, 32'd7};
        drain_check("t4");

        // T5: input held through a stalled drain; S1 item lands, busy inputs counted
        send(22'h31, 32'd30);
        send(22'h32, 32'd20);
        send(22'h33, 32'd10);
        settle();
        chk("t5.drop_before", 64'(drop_cnt), 64'd0);
        bus.input_valid = 1'b1;
        bus.input_addr  = 22'h34;
        bus.input_cnt   = 32'd25;
        bus.drain_start = 1'b1;
        bus.out_ready   = 1'b0;
        tick();
        bus.drain_start = 1'b0;
        chk("t5.flush", 64'(busy), 64'd1);
        tick();
        exp_addr = '{22'h31, 22'h34, 22'h32, 22'h33};
        exp_cnt  = '{32'd30, 32'd25, 32'd20, 32'd10};
        for (int k = 0; k < 4; k++) begin
            bus.out_ready = 1'b0;
            chk($sformatf("t5.valid%0d", k), 64'(bus.out_valid), 64'd1);
            chk($sformatf("t5.addr%0d", k), 64'(bus.out_addr), 64'(exp_addr[k]));
            tick();
            chk($sformatf("t5.hold_addr%0d", k), 64'(bus.out_addr), 64'(exp_addr[k]));
            chk($sformatf("t5.hold_cnt%0d", k), 64'(bus.out_cnt), 64'(exp_cnt[k]));
            chk($sformatf("t5.last%0d", k), 64'(bus.out_last), 64'(k == 3));
            bus.out_ready = 1'b1;
            tick();
        end
        chk("t5.done", 64'(drain_done), 64'd1);
        tick();
        bus.input_valid = 1'b0;
        chk("t5.idle", 64'(busy), 64'd0);
        chk("t5.empty", 64'(num_valid), 64'd0);
        chk("t5.drop_cnt", 64'(drop_cnt), 64'd10);
        exp_addr.delete();
        exp_cnt.delete();
        tick();

        // T6: reset during beat 2, then an empty drain
        send(22'h41, 32'd3);
        send(22'h42, 32'd2);
        send(22'h43, 32'd1);
        settle();
        bus.out_ready   = 1'b1;
        bus.drain_start = 1'b1;
        tick();
        bus.drain_start = 1'b0;
        tick();
        tick();
        chk("t6.beat2_addr", 64'(bus.out_addr), 64'h42);
        #2 rst = 1'b1;
        #1;
        chk("t6.async_valid", 64'(bus.out_valid), 64'd0);
        chk("t6.async_addr", 64'(bus.out_addr), 64'd0);
        chk("t6.async_cnt", 64'(bus.out_cnt), 64'd0);
        chk("t6.async_busy", 64'(busy), 64'd0);
        chk("t6.async_num", 64'(num_valid), 64'd0);
        chk("t6.async_drop", 64'(drop_cnt), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6.post_idle", 64'(busy), 64'd0);
        drain_check("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
